// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle.
// result = {remainder (HI), quotient (LO)}, valid while ready pulses.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_div,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DIVZERO = 2'd1;
    localparam logic [1:0] S_ON      = 2'd2;
    localparam logic [1:0] S_END     = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_rem;
    logic             neg_quo;

    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // Restored remainder is always below the divisor, so it fits in WIDTH bits;
    // only the shifted trial value needs the extra bit.
    assign shifted = {rem, quo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvsr};
    assign rem_n   = ge ? (shifted[WIDTH-1:0] - dvsr) : shifted[WIDTH-1:0];
    assign quo_n   = {quo[WIDTH-2:0], ge};

    // Most-negative stays as its own bit pattern, read as an unsigned magnitude.
    assign a_abs = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_abs = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign busy  = (state == S_DIVZERO) || (state == S_ON);
    assign ready = (state == S_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            neg_rem <= 1'b0;
            neg_quo <= 1'b0;
            result  <= '0;
        end else if (annul) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (b != '0) begin
                            rem     <= '0;
                            quo     <= a_abs;
                            dvsr    <= b_abs;
                            neg_rem <= signed_div & a[WIDTH-1];
                            neg_quo <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                            cnt     <= '0;
                            state   <= S_ON;
                        end else begin
                            // Dividend parked in quo so later operand changes cannot leak in.
                            quo   <= a;
                            state <= S_DIVZERO;
                        end
                    end
                end
                S_ON: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result <= {(neg_rem ? -rem_n : rem_n), (neg_quo ? -quo_n : quo_n)};
                        state  <= S_END;
                    end
                end
                S_DIVZERO: begin
                    result <= {quo, {WIDTH{1'b1}}};
                    state  <= S_END;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// annul, start-in-END and mid-operation reset.
module tb_div_unit;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           signed_div = 1'b0;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;

    int total = 0;
    int bad = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .signed_div(signed_div),
        .start(start), .annul(annul), .result(result), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start in cycle 0; busy must hold for cycles 1..W, ready only in W+1, idle in W+2.
    task automatic run_div(input string tag, input logic [W-1:0] da, input logic [W-1:0] db,
                           input logic sd, input logic [2*W-1:0] exp);
        logic win_ok;
        a = da; b = db; signed_div = sd; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~da; b = ~db; signed_div = ~sd;
        win_ok = 1'b1;
        for (int c = 1; c <= W; c++) begin
            if (!(busy === 1'b1 && ready === 1'b0)) win_ok = 1'b0;
            tick();
        end
        chk({tag, " busy window"}, {63'd0, win_ok}, 64'd1);
        chk({tag, " ready"}, {62'd0, ready, busy}, 64'd2);
        chk({tag, " result"}, result, exp);
        tick();
        chk({tag, " idle after"}, {62'd0, ready, busy}, 64'd0);
        chk({tag, " result held"}, result, exp);
    endtask

    initial begin
        logic none;

        rst = 1'b1; start = 1'b1; annul = 1'b1; b = 32'd3;
        tick();
        rst = 1'b0; start = 1'b0; annul = 1'b0;
        chk("reset result", result, 64'd0);
        chk("reset flags", {62'd0, ready, busy}, 64'd0);
        tick();
        chk("reset idle", {62'd0, ready, busy}, 64'd0);

        run_div("divu 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
        tick();
        run_div("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        tick();
        run_div("divu -7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC});
        tick();
        run_div("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000});
        tick();
        run_div("divu 5/9", 32'd5, 32'd9, 1'b0, {32'd5, 32'd0});
        tick();
        run_div("div 0/-5", 32'd0, 32'hFFFF_FFFB, 1'b1, {32'd0, 32'd0});
        tick();
        run_div("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD});
        tick();

        // Divide by zero
        a = 32'h1234_5678; b = '0; signed_div = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; a = '0;
        chk("dz cycle1", {62'd0, ready, busy}, 64'd1);
        tick();
        chk("dz cycle2", {62'd0, ready, busy}, 64'd2);
        chk("dz result", result, {32'h1234_5678, 32'hFFFF_FFFF});
        tick();
        chk("dz idle", {62'd0, ready, busy}, 64'd0);

        // Annul on cycle 10 of a divide
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        chk("annul pre busy", {63'd0, busy}, 64'd1);
        annul = 1'b1;
        tick();
        annul = 1'b0;
        chk("annul idle", {62'd0, ready, busy}, 64'd0);
        chk("annul result kept", result, {32'h1234_5678, 32'hFFFF_FFFF});
        none = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (ready !== 1'b0 || busy !== 1'b0) none = 1'b0;
            tick();
        end
        chk("annul no ready", {63'd0, none}, 64'd1);

        // Start together with annul is not accepted
        a = 32'd9; b = 32'd3; start = 1'b1; annul = 1'b1;
        tick();
        start = 1'b0; annul = 1'b0;
        chk("start+annul", {62'd0, ready, busy}, 64'd0);
        tick();
        chk("start+annul later", {62'd0, ready, busy}, 64'd0);

        // Start during END is ignored
        a = 32'd9; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= W; c++) tick();
        chk("end ready", {62'd0, ready, busy}, 64'd2);
        chk("end result", result, {32'd0, 32'd3});
        a = 32'd50; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("start in end", {62'd0, ready, busy}, 64'd0);
        tick();
        chk("start in end later", {62'd0, ready, busy}, 64'd0);
        chk("start in end result", result, {32'd0, 32'd3});

        // Annul in END still shows the ready pulse
        a = 32'd20; b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= W; c++) tick();
        annul = 1'b1;
        #1;
        chk("annul in end ready", {62'd0, ready, busy}, 64'd2);
        chk("annul in end result", result, {32'd2, 32'd3});
        tick();
        annul = 1'b0;
        chk("annul in end idle", {62'd0, ready, busy}, 64'd0);

        // Reset in the middle of ON
        a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid result", result, 64'd0);
        chk("rst mid flags", {62'd0, ready, busy}, 64'd0);
        run_div("after rst 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage, alongside the ALU.
- Executes DIV/DIVU and produces a {remainder, quotient} pair that is written into the HI/LO register pair.
- The ALU's MFHI/MFLO paths later read HI/LO.
- The pipeline stalls on busy and captures the result on ready.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH; result width is 2*WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
a  input  WIDTH  dividend (rs)
b  input  WIDTH  divisor (rt)
signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
start  input  1  request; sampled only in IDLE
annul  input  1  flush/exception cancel; aborts any operation in progress
result  output  2*WIDTH  {remainder (HI), quotient (LO)}, registered
ready  output  1  one-cycle pulse, result valid
busy  output  1  high while computing; stalls the pipeline

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, result=0, ready=0, busy=0, counter=0, internal registers cleared. rst has priority over annul and start.
- States: IDLE, DIVZERO, ON, END.
- Outputs by state: busy=1 in DIVZERO and ON, 0 otherwise; ready=1 only in END.
- IDLE transitions:
  - start=1, annul=0, b!=0: latch |a| and |b| (abs only when signed_div=1), the sign of a, the sign of a^b, and signed_div. Clear the partial remainder and set counter=0. Go to ON.
  - start=1, annul=0, b==0: go to DIVZERO.
  - Otherwise stay in IDLE.
- ON, one iteration per cycle:
  - Shift {rem, quo} left 1, bringing in the next dividend bit.
  - Trial subtract divisor from the WIDTH+1-bit remainder.
  - If the result is non-negative, keep the difference and set quotient LSB=1; else restore and set LSB=0.
  - counter++. After WIDTH iterations (counter==WIDTH-1 at the edge), go to END.
- END:
  - result is updated at the ON->END edge and is valid while ready=1.
  - Signed fixup: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Always go to IDLE next cycle.
  - start is ignored in END; back-to-back divides need one IDLE cycle.
- DIVZERO: result={a, all-ones}, independent of signed_div; go to END.
- Latency: start high in cycle 0 with b!=0 gives busy in cycles 1..WIDTH, ready in cycle WIDTH+1, IDLE in cycle WIDTH+2. For divide-by-zero: busy in cycle 1, ready in cycle 2.
- result holds its value after ready drops, until the next ready. No update while IDLE or ON.
- annul=1 in any state: next state is IDLE with ready=0, busy=0, result unchanged.
  - annul and start in the same IDLE cycle: annul wins, nothing starts.
  - annul in the END cycle: the ready pulse still occurs this cycle and the FSM goes to IDLE.
- Operand changes on a/b after acceptance have no effect.
- Arithmetic edge cases:
  - Signed most-negative / -1: quotient wraps to most-negative, remainder 0.
  - Abs of most-negative is handled as an unsigned WIDTH-bit magnitude, with no overflow flag.
  - 0 / x: quotient 0, remainder 0.
  - Unsigned x/y with x<y: quotient 0, remainder x.
- Only WIDTH-bit operations appear here. There is no exception output; overflow is undefined-result by ISA and is handled as above.

Test Plan:
1. DIVU a=100, b=7, start in cycle 0. Required: busy cycles 1..32; ready only in cycle 33 with result={32'd2, 32'd14}; busy=0 and ready=0 in cycle 34.
2. DIV signed a=-7 (0xFFFFFFF9), b=2. Required: result={0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quo -3). Same operands with signed_div=0: result={32'd1, 0x7FFFFFFC}.
3. DIV a=0x80000000, b=0xFFFFFFFF. Required: result={0, 0x80000000}. DIVU a=5, b=9: result={5, 0}.
4. b=0, a=0x12345678, start in cycle 0. Required: busy in cycle 1, ready in cycle 2 with result={0x12345678, 0xFFFFFFFF}.
5. Annul on cycle 10 mid-divide. Required: cycle 11 IDLE, no ready pulse, result equals the prior value. Start asserted together with annul: not accepted. Start in END: ignored.
6. Assert rst mid-ON (cycle 5). Required: next cycle result=0, busy=0, ready=0. A new start then completes normally with correct latency (ready 33 cycles after start).
